// File: rtl/ym3438_pkg.sv
// Shared timing constants and types for the YM3438 FM core.
package ym3438_pkg;

  localparam int unsigned YM_PRESC_DIV = 6;
  localparam int unsigned YM_C2_PHASE  = 3;
  localparam int unsigned YM_SLOTS     = 24;
  localparam int unsigned YM_SLOT_W    = 5;

  typedef logic [YM_SLOT_W-1:0] ym_slot_t;

endpackage

// File: rtl/ym3438_slot_cnt.sv
// Two-phase slot counter: next value computed on c1, committed on c2.
module ym3438_slot_cnt
  import ym3438_pkg::*;
#(
  parameter int unsigned SLOTS = YM_SLOTS
) (
  input  logic     MCLK,
  input  logic     reset,
  input  logic     c1,
  input  logic     c2,
  input  logic     clr,
  output ym_slot_t slot,
  output logic     wrap
);

  localparam ym_slot_t SlotMax = ym_slot_t'(SLOTS - 1);

  ym_slot_t slot_next;

  // wrap marks a natural SlotMax -> 0 rollover; a forced zero never sets it.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      slot_next <= '0;
      slot      <= '0;
      wrap      <= 1'b0;
    end else begin
      if (c1) begin
        wrap      <= !clr && (slot == SlotMax);
        slot_next <= (clr || slot == SlotMax) ? '0 : slot + ym_slot_t'(1);
      end
      if (c2) begin
        slot <= slot_next;
      end
    end
  end

endmodule

// File: rtl/ym3438_prescaler.sv
// Timing front end: c1/c2 phase enables, slot counter and IC-pin reset synchroniser.
module ym3438_prescaler
  import ym3438_pkg::*;
#(
  parameter int unsigned PRESC_DIV = YM_PRESC_DIV,
  parameter int unsigned C2_PHASE  = YM_C2_PHASE,
  parameter int unsigned SLOTS     = YM_SLOTS
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       ic,
  output logic       c1,
  output logic       c2,
  output logic [4:0] slot,
  output logic       slot0,
  output logic       slot_last,
  output logic       ic_rst
);

  localparam logic [2:0] PrescMax = 3'(PRESC_DIV - 1);
  localparam logic [2:0] C2Count  = 3'(C2_PHASE);
  localparam ym_slot_t   SlotMax  = ym_slot_t'(SLOTS - 1);

  logic [2:0] presc;
  logic       ic_s1;
  logic       ic_s2;
  logic       slot_wrap;
  ym_slot_t   slot_cnt;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clk_en) begin
      presc <= (presc == PrescMax) ? 3'd0 : presc + 3'd1;
    end
  end

  assign c1 = clk_en && (presc == 3'd0);
  assign c2 = clk_en && (presc == C2Count);

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      ic_s1 <= 1'b1;
      ic_s2 <= 1'b1;
    end else if (c1) begin
      ic_s1 <= ic;
      ic_s2 <= ic_s1;
    end
  end

  // Set whenever the synchroniser output goes (or stays) high; released only by a natural wrap.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      ic_rst <= 1'b1;
    end else if (c1 && ic_s1) begin
      ic_rst <= 1'b1;
    end else if (c2 && slot_wrap) begin
      ic_rst <= 1'b0;
    end
  end

  ym3438_slot_cnt #(
    .SLOTS(SLOTS)
  ) u_slot_cnt (
    .MCLK (MCLK),
    .reset(reset),
    .c1   (c1),
    .c2   (c2),
    .clr  (ic_s2),
    .slot (slot_cnt),
    .wrap (slot_wrap)
  );

  assign slot      = slot_cnt;
  assign slot0     = (slot_cnt == '0);
  assign slot_last = (slot_cnt == SlotMax);

endmodule

// File: tb/tb_ym3438_prescaler.sv
// Directed bench for ym3438_prescaler: default build plus a small 4/2/8 build.
module tb_ym3438_prescaler;

  logic       MCLK = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       ic = 1'b0;
  logic       c1, c2, slot0, slot_last, ic_rst;
  logic [4:0] slot;
  logic       c1_s, c2_s, slot0_s, slot_last_s, ic_rst_s;
  logic [4:0] slot_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 MCLK = ~MCLK;

  ym3438_prescaler u_dut (
    .MCLK     (MCLK),
    .reset    (reset),
    .clk_en   (clk_en),
    .ic       (ic),
    .c1       (c1),
    .c2       (c2),
    .slot     (slot),
    .slot0    (slot0),
    .slot_last(slot_last),
    .ic_rst   (ic_rst)
  );

  ym3438_prescaler #(
    .PRESC_DIV(4),
    .C2_PHASE (2),
    .SLOTS    (8)
  ) u_small (
    .MCLK     (MCLK),
    .reset    (reset),
    .clk_en   (clk_en),
    .ic       (ic),
    .c1       (c1_s),
    .c2       (c2_s),
    .slot     (slot_s),
    .slot0    (slot0_s),
    .slot_last(slot_last_s),
    .ic_rst   (ic_rst_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Slot seen after the c2 of phi cycle k following reset with ic low.
  function automatic int exp_slot(input int k, input int n);
    return (k < 2) ? 0 : (k - 1) % n;
  endfunction

  task automatic apply_reset();
    @(negedge MCLK);
    reset  = 1'b1;
    clk_en = 1'b0;
    ic     = 1'b0;
    @(posedge MCLK);
    @(negedge MCLK);
    check("rst_c1", 32'(c1), 32'd0);
    check("rst_c2", 32'(c2), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_slot0", 32'(slot0), 32'd1);
    check("rst_slot_last", 32'(slot_last), 32'd0);
    check("rst_ic_rst", 32'(ic_rst), 32'd1);
    check("rst_small_slot", 32'(slot_s), 32'd0);
    check("rst_small_ic_rst", 32'(ic_rst_s), 32'd1);
    reset = 1'b0;
  endtask

  task automatic run_power_on(input logic gaps);
    logic [3:0] pat;
    logic       en, c2_tick, c2s_tick;
    int         t, m, k, es;
    pat = 4'b1001;
    t = 0;
    m = 0;
    while (t < 156) begin
      en = gaps ? pat[m[1:0]] : 1'b1;
      clk_en = en;
      c2_tick  = en && (t % 6 == 3);
      c2s_tick = en && (t % 4 == 2);
      #1;
      if (m < 40) begin
        check("c1_phase", 32'(c1), 32'(en && (t % 6 == 0)));
        check("c2_phase", 32'(c2), 32'(en && (t % 6 == 3)));
        check("c1c2_excl", 32'(c1 && c2), 32'd0);
        check("small_c1_phase", 32'(c1_s), 32'(en && (t % 4 == 0)));
        check("small_c2_phase", 32'(c2_s), 32'(en && (t % 4 == 2)));
      end
      @(posedge MCLK);
      @(negedge MCLK);
      if (en) t++;
      m++;
      if (c2_tick) begin
        k  = (t - 1) / 6;
        es = exp_slot(k, 24);
        check("slot_seq", 32'(slot), 32'(es));
        check("slot0", 32'(slot0), 32'(es == 0));
        check("slot_last", 32'(slot_last), 32'(es == 23));
        check("poweron_ic_rst", 32'(ic_rst), 32'(k < 25));
      end
      if (c2s_tick && ((t - 1) / 4 <= 12)) begin
        k  = (t - 1) / 4;
        es = exp_slot(k, 8);
        check("small_slot_seq", 32'(slot_s), 32'(es));
        check("small_slot_last", 32'(slot_last_s), 32'(es == 7));
        check("small_ic_rst", 32'(ic_rst_s), 32'(k < 9));
      end
    end
  endtask

  // One full phi cycle with clk_en high, starting at the negedge before its c1 edge.
  task automatic phi(input logic ic_val);
    ic     = ic_val;
    clk_en = 1'b1;
    #1;
    check("phi_align_c1", 32'(c1), 32'd1);
    repeat (6) begin
      @(posedge MCLK);
      @(negedge MCLK);
    end
  endtask

  initial begin
    int es;
    logic er;

    apply_reset();
    run_power_on(1'b0);

    apply_reset();
    run_power_on(1'b1);

    // IC pulse mid-count after the power-on clear has completed.
    apply_reset();
    for (int cyc = 0; cyc <= 35; cyc++) phi(1'b0);
    check("pre_ic_slot", 32'(slot), 32'd10);
    check("pre_ic_ic_rst", 32'(ic_rst), 32'd0);
    for (int cyc = 36; cyc <= 65; cyc++) begin
      phi(cyc <= 38);
      es = (cyc == 36) ? 11 : (cyc == 37) ? 12 : (cyc <= 40) ? 0 :
           (cyc <= 63) ? cyc - 40 : cyc - 64;
      er = (cyc >= 37) && (cyc <= 63);
      check("ic_slot", 32'(slot), 32'(es));
      check("ic_ic_rst", 32'(ic_rst), 32'(er));
    end

    // Async reset between c1 and c2 while slot is 17.
    for (int cyc = 66; cyc <= 81; cyc++) phi(1'b0);
    check("pre_rst_slot", 32'(slot), 32'd17);
    ic     = 1'b0;
    clk_en = 1'b1;
    repeat (2) begin
      @(posedge MCLK);
      @(negedge MCLK);
    end
    check("mid_c1", 32'(c1), 32'd0);
    check("mid_c2", 32'(c2), 32'd0);
    check("mid_slot_held", 32'(slot), 32'd17);
    reset = 1'b1;
    #1;
    check("async_slot", 32'(slot), 32'd0);
    check("async_slot0", 32'(slot0), 32'd1);
    check("async_ic_rst", 32'(ic_rst), 32'd1);
    check("async_presc_c1", 32'(c1), 32'd1);
    check("async_c2", 32'(c2), 32'd0);
    @(posedge MCLK);
    @(negedge MCLK);
    reset  = 1'b0;
    clk_en = 1'b0;
    #1;
    check("post_rst_c1_idle", 32'(c1), 32'd0);
    @(posedge MCLK);
    @(negedge MCLK);
    check("post_rst_slot", 32'(slot), 32'd0);
    clk_en = 1'b1;
    #1;
    check("post_rst_first_c1", 32'(c1), 32'd1);
    @(posedge MCLK);
    @(negedge MCLK);
    check("post_rst_second_c1", 32'(c1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
